// File: rtl/fft_frame_serializer_pkg.sv
// Shared types for the FFT output path: complex sample format, serializer states
// and a small index-width helper.
package fft_frame_serializer_pkg;

    localparam int CP_W    = 16;
    localparam int CP_BITS = 2 * CP_W;

    typedef struct packed {
        logic signed [CP_W-1:0] re;
        logic signed [CP_W-1:0] im;
    } complex_product_t;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_t;

    // Index width that stays legal (>=1 bit) even for a single-entry table.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of storage: parallel load of all N samples, read back as an
// (even, odd) pair selected by the pair index.
module fft_frame_bank
    import fft_frame_serializer_pkg::*;
#(
    parameter int N     = 8,
    parameter int PAIRS = N / 2,
    localparam int KW   = idx_w(PAIRS)
) (
    input  logic                   clk,
    input  logic                   i_load,
    input  complex_product_t [N-1:0] i_frame,
    input  logic [KW-1:0]          i_pair,
    output complex_product_t       o_even,
    output complex_product_t       o_odd
);

    // Stored pre-split by parity so each read port is a plain PAIRS-way mux.
    complex_product_t r_even [PAIRS];
    complex_product_t r_odd  [PAIRS];

    generate
        for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
            always_ff @(posedge clk) begin
                if (i_load) begin
                    r_even[gi] <= i_frame[2*gi];
                    r_odd[gi]  <= i_frame[2*gi+1];
                end
            end
        end
    endgenerate

    assign o_even = r_even[i_pair];
    assign o_odd  = r_odd[i_pair];

endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong buffer turning a parallel FFT frame into a stream of sample pairs
// with valid/ready handshake, dropping frames (with an overflow pulse) when full.
module fft_frame_serializer
    import fft_frame_serializer_pkg::*;
#(
    parameter int N     = 8,
    parameter int PAIRS = N / 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  complex_product_t [N-1:0] frame_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output complex_product_t         data_out_0,
    output complex_product_t         data_out_1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     overflow
);

    localparam int KW = idx_w(PAIRS);
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

    ser_state_t       r_state, w_state_next;
    logic [1:0]       r_full, w_full_next;
    logic             r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
    logic [KW-1:0]    r_k, w_k_next;
    logic             r_overflow;
    logic             w_capture, w_drop, w_out_valid, w_xfer, w_release;
    complex_product_t w_even [2];
    complex_product_t w_odd  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            fft_frame_bank #(
                .N     (N),
                .PAIRS (PAIRS)
            ) u_bank (
                .clk     (clk),
                .i_load  (w_capture && (r_wr_ptr == 1'(gi))),
                .i_frame (frame_in),
                .i_pair  (r_k),
                .o_even  (w_even[gi]),
                .o_odd   (w_odd[gi])
            );
        end
    endgenerate

    // Ready comes from registered flags only, so a same-cycle release never frees a slot.
    assign in_ready    = ~(r_full[0] & r_full[1]);
    assign w_capture   = in_valid & in_ready;
    assign w_drop      = in_valid & ~in_ready;
    assign w_out_valid = (r_state == ST_STREAM);
    assign w_xfer      = w_out_valid & out_ready;
    assign w_release   = w_xfer & (r_k == K_LAST);

    always_comb begin
        w_full_next   = r_full;
        w_rd_ptr_next = r_rd_ptr ^ w_release;
        w_k_next      = r_k;
        w_state_next  = r_state;

        // The write bank is always the free one when capturing, so these never collide.
        if (w_release) w_full_next[r_rd_ptr] = 1'b0;
        if (w_capture) w_full_next[r_wr_ptr] = 1'b1;

        if (w_release)   w_k_next = '0;
        else if (w_xfer) w_k_next = r_k + KW'(1);

        case (r_state)
            ST_EMPTY: begin
                if (w_full_next[w_rd_ptr_next]) w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_release)
                    w_state_next = w_full_next[w_rd_ptr_next] ? ST_STREAM : ST_EMPTY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_full     <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_k        <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_full     <= w_full_next;
            r_wr_ptr   <= r_wr_ptr ^ w_capture;
            r_rd_ptr   <= w_rd_ptr_next;
            r_k        <= w_k_next;
            r_overflow <= w_drop;
        end
    end

    assign out_valid  = w_out_valid;
    assign out_last   = w_out_valid & (r_k == K_LAST);
    assign overflow   = r_overflow;
    assign data_out_0 = w_out_valid ? w_even[r_rd_ptr] : '0;
    assign data_out_1 = w_out_valid ? w_odd[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Serializer bench: directed scenarios plus random traffic, all checked against
// a queue-of-frames reference model.
module tb_fft_frame_serializer;
    import fft_frame_serializer_pkg::*;

    localparam int N     = 8;
    localparam int PAIRS = N / 2;
    localparam int SW    = $bits(complex_product_t);
    localparam int FW    = N * SW;

    logic                     clk = 1'b0;
    logic                     reset;
    complex_product_t [N-1:0] frame_in;
    logic                     in_valid;
    logic                     in_ready;
    complex_product_t         data_out_0;
    complex_product_t         data_out_1;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     overflow;

    fft_frame_serializer #(.N(N), .PAIRS(PAIRS)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_in   (frame_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: frames accepted but not yet fully sent, oldest first.
    logic [FW-1:0] m_q[$];
    int            m_k   = 0;
    logic          m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] ramp_frame(input int base);
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) f[i*SW +: SW] = {CP_W'(base + i + 1), CP_W'(0)};
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) f[i*SW +: SW] = SW'($urandom);
        return f;
    endfunction

    // Called at the falling edge: drive inputs, check outputs, advance one clock.
    task automatic step(input logic rst, input logic iv, input logic [FW-1:0] fr, input logic ordy);
        logic          exp_v;
        logic [SW-1:0] exp_d0, exp_d1;
        logic [FW-1:0] head;
        int            occ;
        reset = rst; in_valid = iv; frame_in = fr; out_ready = ordy;

        occ    = m_q.size();
        exp_v  = (occ > 0);
        exp_d0 = '0;
        exp_d1 = '0;
        if (exp_v) begin
            head   = m_q[0];
            exp_d0 = head[(2*m_k)*SW +: SW];
            exp_d1 = head[(2*m_k+1)*SW +: SW];
        end
        check("in_ready",   64'(in_ready),   64'(occ < 2));
        check("out_valid",  64'(out_valid),  64'(exp_v));
        check("out_last",   64'(out_last),   64'(exp_v && (m_k == PAIRS-1)));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("data_out_0", 64'(data_out_0), 64'(exp_d0));
        check("data_out_1", 64'(data_out_1), 64'(exp_d1));
        if (exp_v && ordy && !rst)
            $display("pair k=%0d d0=%h d1=%h last=%0b", m_k, exp_d0, exp_d1, m_k == PAIRS-1);

        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_k   = 0;
            m_ovf = 1'b0;
        end else begin
            m_ovf = iv && (occ >= 2);
            if (exp_v && ordy) begin
                if (m_k == PAIRS-1) begin
                    void'(m_q.pop_front());
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end
            if (iv && occ < 2) m_q.push_back(fr);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_frame(), ordy);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; frame_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then a single ramp frame at full rate.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, ramp_frame(0), 1'b1);
        idle(6, 1'b1);

        // Backpressure during pair 1.
        step(1'b0, 1'b1, ramp_frame(10), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Back-to-back frames, consumer always ready.
        step(1'b0, 1'b1, ramp_frame(20), 1'b1);
        step(1'b0, 1'b1, ramp_frame(30), 1'b1);
        idle(10, 1'b1);

        // Overflow: three frames with consumer stalled, then drain.
        step(1'b0, 1'b1, ramp_frame(40), 1'b0);
        step(1'b0, 1'b1, ramp_frame(50), 1'b0);
        step(1'b0, 1'b1, ramp_frame(60), 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // Reset after two transfers, then a fresh frame.
        step(1'b0, 1'b1, ramp_frame(70), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, ramp_frame(80), 1'b1);
        idle(6, 1'b1);

        // Both banks full; new frame arrives on the final-pair transfer.
        step(1'b0, 1'b1, ramp_frame(90), 1'b0);
        step(1'b0, 1'b1, ramp_frame(100), 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b1, ramp_frame(110), 1'b1);
        idle(8, 1'b1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++)
            step($urandom_range(199) == 0, $urandom_range(3) == 0, rand_frame(),
                 $urandom_range(9) < 7);
        idle(10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
